// File: rtl/fence_sequencer_if.sv
// Handshake bundle between the commit stage and the fence sequencer.
// The commit side uses the master modport, the sequencer uses the slave modport.
interface fence_sequencer_if;
   logic       req_valid_i;
   logic [1:0] req_op_i;
   logic       halt_i;
   logic       no_st_pending_i;
   logic       dcache_flush_o;
   logic       dcache_flush_ack_i;
   logic       icache_flush_o;
   logic       tlb_flush_o;
   logic       done_o;
   logic       flush_pipeline_o;
   logic       busy_o;
   logic       timeout_o;

   modport master (
      output req_valid_i, req_op_i, halt_i, no_st_pending_i, dcache_flush_ack_i,
      input  dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, flush_pipeline_o,
             busy_o, timeout_o
   );

   modport slave (
      input  req_valid_i, req_op_i, halt_i, no_st_pending_i, dcache_flush_ack_i,
      output dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, flush_pipeline_o,
             busy_o, timeout_o
   );
endinterface

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA at commit port 0: store-buffer drain, D$/I$/TLB flushes, done strobe.
// Optional drain/flush watchdog is compiled in with the FENCE_SEQ_TIMEOUT_EN macro.
module fence_sequencer #(
   parameter int unsigned QUIET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic              clk_i,
   input logic              rst_ni,
   fence_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_DFLUSH,
      S_IFLUSH,
      S_TLB,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_FENCE_I = 2'b01;
   localparam logic [1:0] OP_SFENCE  = 2'b10;
   localparam logic [1:0] OP_NOP     = 2'b11;
   localparam logic [3:0] QUIET_LAST = 4'(QUIET_CYCLES - 1);

   state_t     state;
   logic [1:0] op_q;
   logic [3:0] quiet_cnt;
   logic       dcache_flush_q;
   logic       icache_flush_q;
   logic       tlb_flush_q;
   logic       done_q;
   logic       busy_q;

   // Outputs are registered alongside each transition so they always match the state being entered.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state          <= S_IDLE;
         op_q           <= 2'b00;
         quiet_cnt      <= 4'd0;
         dcache_flush_q <= 1'b0;
         icache_flush_q <= 1'b0;
         tlb_flush_q    <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         icache_flush_q <= 1'b0;
         tlb_flush_q    <= 1'b0;
         done_q         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req_valid_i && !bus.halt_i) begin
                  op_q      <= bus.req_op_i;
                  quiet_cnt <= 4'd0;
                  busy_q    <= 1'b1;
                  if (bus.req_op_i == OP_NOP) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (!bus.no_st_pending_i) begin
                  quiet_cnt <= 4'd0;
               end else if (quiet_cnt == QUIET_LAST) begin
                  if (op_q == OP_SFENCE) begin
                     state       <= S_TLB;
                     tlb_flush_q <= 1'b1;
                  end else begin
                     state          <= S_DFLUSH;
                     dcache_flush_q <= 1'b1;
                  end
               end else begin
                  quiet_cnt <= quiet_cnt + 4'd1;
               end
            end
            S_DFLUSH: begin
               if (bus.dcache_flush_ack_i) begin
                  dcache_flush_q <= 1'b0;
                  if (op_q == OP_FENCE_I) begin
                     state          <= S_IFLUSH;
                     icache_flush_q <= 1'b1;
                  end else begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            S_IFLUSH, S_TLB: begin
               state  <= S_DONE;
               done_q <= 1'b1;
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state          <= S_IDLE;
               busy_q         <= 1'b0;
               dcache_flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dcache_flush_o   = dcache_flush_q;
   assign bus.icache_flush_o   = icache_flush_q;
   assign bus.tlb_flush_o      = tlb_flush_q;
   assign bus.done_o           = done_q;
   assign bus.flush_pipeline_o = done_q;
   assign bus.busy_o           = busy_q;

`ifdef FENCE_SEQ_TIMEOUT_EN
   localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // Watchdog only observes the sequence; a new acceptance starts a fresh count and clears the flag.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if (state == S_IDLE && bus.req_valid_i && !bus.halt_i) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if ((state == S_DRAIN || state == S_DFLUSH) && wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_cnt == WD_LAST) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.timeout_o = timeout_q;
`else
   assign bus.timeout_o = 1'b0;
`endif

endmodule
